// File: rtl/pipe_hold_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_hold_ctrl_if                                          |
// | Brief    : Hazard/redirect signal bundle between the pipeline and    |
// |            the hold controller.                                       |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface pipe_hold_ctrl_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        ex_load_i;
  logic [4:0]  ex_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        int_pending_o;
  logic        stall_timeout_o;

  // Pipeline side: raises requests, consumes hold code and redirect
  modport master (
    output jump_flag_i, jump_addr_i, int_assert_i, int_addr_i, hold_ex_i,
           hold_bus_i, ex_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, int_pending_o, stall_timeout_o
  );

  // Controller side
  modport slave (
    input  jump_flag_i, jump_addr_i, int_assert_i, int_addr_i, hold_ex_i,
           hold_bus_i, ex_load_i, ex_rd_i, id_rs1_i, id_rs2_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, int_pending_o, stall_timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hold_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_hold_ctrl                                             |
// | Brief    : Pipeline hazard/redirect controller. Arbitrates jump,     |
// |            interrupt, EX stall, load-use and bus wait into a hold    |
// |            code plus PC redirect, and sequences the redirect flush.  |
// |            Optional stall watchdog: define PIPE_STALL_WATCHDOG_EN.   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 1,   // Hold_Id cycles per redirect, 1..15
  parameter int TIMEOUT      = 1024 // watchdog trip count
) (
  input wire              clk,
  input wire              rstn,
  pipe_hold_ctrl_if.slave bus
);

  localparam logic [2:0] c_HOLD_NONE = 3'd0;
  localparam logic [2:0] c_HOLD_PC   = 3'd1;
  localparam logic [2:0] c_HOLD_ID   = 3'd3;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic [3:0]  r_cnt,      w_cnt_nxt;
  logic        r_int_pend, w_int_pend_nxt;
  logic [31:0] r_int_addr, w_int_addr_nxt;
  logic [31:0] r_jump_addr, w_jump_addr_nxt;

  logic        w_load_use;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [2:0]  w_hold;
  logic        w_jflag;
  logic [31:0] w_jaddr;

  // x0 is hard-wired zero, so a load into it can never be a hazard
  assign w_load_use = bus.ex_load_i && (bus.ex_rd_i != 5'd0) &&
                      ((bus.ex_rd_i == bus.id_rs1_i) || (bus.ex_rd_i == bus.id_rs2_i));

  // State, flush counter, pending interrupt and last redirect target
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_RUN;
      r_cnt       <= 4'd0;
      r_int_pend  <= 1'b0;
      r_int_addr  <= 32'd0;
      r_jump_addr <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_int_pend  <= w_int_pend_nxt;
      r_int_addr  <= w_int_addr_nxt;
      r_jump_addr <= w_jump_addr_nxt;
    end
  end

  // Redirect arbitration, hold priority and next-state computation
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_int_pend_nxt  = r_int_pend;
    w_int_addr_nxt  = r_int_addr;
    w_jump_addr_nxt = r_jump_addr;
    w_redirect      = 1'b0;
    w_target        = bus.jump_addr_i;
    w_hold          = c_HOLD_NONE;
    w_jflag         = 1'b0;
    w_jaddr         = r_jump_addr;

    case (r_state)
      S_RUN: begin
        // Interrupt (pending first, then fresh) always beats a jump
        if (r_int_pend && !bus.hold_ex_i) begin
          w_redirect     = 1'b1;
          w_target       = r_int_addr;
          w_int_pend_nxt = 1'b0;
        end else if (bus.int_assert_i && !bus.hold_ex_i) begin
          w_redirect = 1'b1;
          w_target   = bus.int_addr_i;
        end else if (bus.jump_flag_i) begin
          w_redirect = 1'b1;
          w_target   = bus.jump_addr_i;
        end

        if (w_redirect) begin
          w_hold          = c_HOLD_ID;
          w_jflag         = 1'b1;
          w_jaddr         = w_target;
          w_jump_addr_nxt = w_target;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = 4'(FLUSH_CYCLES - 1);
          end
        end else if (bus.hold_ex_i) begin
          w_hold = c_HOLD_ID;
        end else if (w_load_use) begin
          w_hold = c_HOLD_ID;
        end else if (bus.hold_bus_i) begin
          w_hold = c_HOLD_PC;
        end
      end
      S_FLUSH: begin
        // EX only holds bubbles here, so jump/hold inputs are ignored
        w_hold = c_HOLD_ID;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // Interrupts that cannot be taken now are deferred; first one wins
    if (bus.int_assert_i && !r_int_pend && (r_state == S_FLUSH || bus.hold_ex_i)) begin
      w_int_pend_nxt = 1'b1;
      w_int_addr_nxt = bus.int_addr_i;
    end

    // Outputs read as idle while reset is asserted
    if (!rstn) begin
      w_hold  = c_HOLD_NONE;
      w_jflag = 1'b0;
      w_jaddr = 32'd0;
    end
  end

  assign bus.hold_flag_o   = w_hold;
  assign bus.jump_flag_o   = w_jflag;
  assign bus.jump_addr_o   = w_jaddr;
  assign bus.int_pending_o = r_int_pend;

`ifdef PIPE_STALL_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
  logic [15:0] w_wd_nxt;
  logic        r_timeout;

  // Saturating count of consecutive held cycles
  always_comb begin
    w_wd_nxt = r_wd_cnt;
    if (w_hold == c_HOLD_NONE) begin
      w_wd_nxt = 16'd0;
    end else if (r_wd_cnt != 16'hFFFF) begin
      w_wd_nxt = r_wd_cnt + 16'd1;
    end
  end

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wd_cnt  <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_nxt;
      if (w_wd_nxt == 16'(TIMEOUT)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.stall_timeout_o = r_timeout;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout    = 32'(TIMEOUT);
  assign bus.stall_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hold_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pipe_hold_ctrl                                          |
// | Brief    : Directed self-checking bench for pipe_hold_ctrl           |
// |            (FLUSH_CYCLES=3, TIMEOUT=8).                               |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_pipe_hold_ctrl;

`ifdef PIPE_STALL_WATCHDOG_EN
  localparam logic c_WD = 1'b1;
`else
  localparam logic c_WD = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;

  pipe_hold_ctrl_if u_if ();

  pipe_hold_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(8)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    u_if.jump_flag_i  = 1'b0;
    u_if.jump_addr_i  = 32'd0;
    u_if.int_assert_i = 1'b0;
    u_if.int_addr_i   = 32'd0;
    u_if.hold_ex_i    = 1'b0;
    u_if.hold_bus_i   = 1'b0;
    u_if.ex_load_i    = 1'b0;
    u_if.ex_rd_i      = 5'd0;
    u_if.id_rs1_i     = 5'd0;
    u_if.id_rs2_i     = 5'd0;
  endtask

  // Advance to the next cycle: inputs change on the falling edge
  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hold"}, 32'(u_if.hold_flag_o), 32'd0);
    chk({tag, "_jf"},   32'(u_if.jump_flag_o), 32'd0);
    chk({tag, "_ja"},   u_if.jump_addr_o,      32'd0);
    chk({tag, "_pend"}, 32'(u_if.int_pending_o), 32'd0);
    chk({tag, "_to"},   32'(u_if.stall_timeout_o), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    // Reset state, with a jump request present to show outputs are gated
    u_if.jump_flag_i = 1'b1;
    u_if.jump_addr_i = 32'h0000_0AAA;
    #1;
    chk_all_zero("rst");
    nxt();
    rstn = 1'b1;
    #1; chk("idle_hold", 32'(u_if.hold_flag_o), 32'd0);

    // Redirect flush: 0x100, three cycles of Hold_Id
    nxt(); u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h100; #1;
    chk("jmp_c0_jf", 32'(u_if.jump_flag_o), 32'd1);
    chk("jmp_c0_ja", u_if.jump_addr_o, 32'h100);
    chk("jmp_c0_hold", 32'(u_if.hold_flag_o), 32'd3);
    nxt(); u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h555; u_if.hold_bus_i = 1'b1; #1;
    chk("jmp_c1_hold", 32'(u_if.hold_flag_o), 32'd3);
    chk("jmp_c1_jf", 32'(u_if.jump_flag_o), 32'd0);
    chk("jmp_c1_ja", u_if.jump_addr_o, 32'h100);
    nxt(); #1; chk("jmp_c2_hold", 32'(u_if.hold_flag_o), 32'd3);
    nxt(); #1; chk("jmp_c3_hold", 32'(u_if.hold_flag_o), 32'd0);

    // Deferred interrupt: hold_ex for 4 cycles, int pulse in cycle 1
    nxt(); u_if.hold_ex_i = 1'b1; #1;
    chk("dint_c0_hold", 32'(u_if.hold_flag_o), 32'd3);
    nxt(); u_if.hold_ex_i = 1'b1; u_if.int_assert_i = 1'b1; u_if.int_addr_i = 32'h80; #1;
    chk("dint_c1_jf", 32'(u_if.jump_flag_o), 32'd0);
    chk("dint_c1_pend", 32'(u_if.int_pending_o), 32'd0);
    nxt(); u_if.hold_ex_i = 1'b1; #1;
    chk("dint_c2_pend", 32'(u_if.int_pending_o), 32'd1);
    nxt(); u_if.hold_ex_i = 1'b1; u_if.int_assert_i = 1'b1; u_if.int_addr_i = 32'h44; #1;
    chk("dint_c3_jf", 32'(u_if.jump_flag_o), 32'd0);
    nxt(); #1;
    chk("dint_c4_jf", 32'(u_if.jump_flag_o), 32'd1);
    chk("dint_c4_ja", u_if.jump_addr_o, 32'h80);
    chk("dint_c4_hold", 32'(u_if.hold_flag_o), 32'd3);
    nxt(); #1;
    chk("dint_c5_pend", 32'(u_if.int_pending_o), 32'd0);
    chk("dint_c5_hold", 32'(u_if.hold_flag_o), 32'd3);
    nxt(); #1;
    nxt(); #1; chk("dint_c7_hold", 32'(u_if.hold_flag_o), 32'd0);

    // Interrupt beats a same-cycle jump
    nxt(); u_if.int_assert_i = 1'b1; u_if.int_addr_i = 32'h80;
    u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h200; #1;
    chk("ivj_jf", 32'(u_if.jump_flag_o), 32'd1);
    chk("ivj_ja", u_if.jump_addr_o, 32'h80);
    nxt(); #1;
    nxt(); #1;
    nxt(); #1;
    chk("ivj_after_ja", u_if.jump_addr_o, 32'h80);
    chk("ivj_after_hold", 32'(u_if.hold_flag_o), 32'd0);
    chk("ivj_after_pend", 32'(u_if.int_pending_o), 32'd0);

    // Load-use hazard, then the bubble clears ex_load_i
    nxt(); u_if.ex_load_i = 1'b1; u_if.ex_rd_i = 5'd5; u_if.id_rs1_i = 5'd3; u_if.id_rs2_i = 5'd5; #1;
    chk("lu_hold", 32'(u_if.hold_flag_o), 32'd3);
    chk("lu_jf", 32'(u_if.jump_flag_o), 32'd0);
    nxt(); u_if.ex_rd_i = 5'd5; u_if.id_rs2_i = 5'd5; #1;
    chk("lu_bubble_hold", 32'(u_if.hold_flag_o), 32'd0);
    nxt(); u_if.ex_load_i = 1'b1; u_if.ex_rd_i = 5'd0; u_if.id_rs1_i = 5'd0; u_if.id_rs2_i = 5'd0; #1;
    chk("lu_x0_hold", 32'(u_if.hold_flag_o), 32'd0);
    nxt(); u_if.ex_load_i = 1'b1; u_if.ex_rd_i = 5'd7; u_if.id_rs1_i = 5'd6; u_if.id_rs2_i = 5'd8; #1;
    chk("lu_nomatch_hold", 32'(u_if.hold_flag_o), 32'd0);

    // Bus vs EX vs load-use priority
    nxt(); u_if.hold_bus_i = 1'b1; #1;
    chk("bus_hold", 32'(u_if.hold_flag_o), 32'd1);
    nxt(); u_if.hold_bus_i = 1'b1; u_if.hold_ex_i = 1'b1; #1;
    chk("bus_ex_hold", 32'(u_if.hold_flag_o), 32'd3);
    nxt(); u_if.hold_bus_i = 1'b1; u_if.ex_load_i = 1'b1; u_if.ex_rd_i = 5'd9; u_if.id_rs1_i = 5'd9; #1;
    chk("bus_lu_hold", 32'(u_if.hold_flag_o), 32'd3);

    // Interrupt arriving during a flush is deferred to its end
    nxt(); u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h300; #1;
    chk("fint_c0_ja", u_if.jump_addr_o, 32'h300);
    nxt(); u_if.int_assert_i = 1'b1; u_if.int_addr_i = 32'h90; #1;
    chk("fint_c1_jf", 32'(u_if.jump_flag_o), 32'd0);
    nxt(); #1;
    chk("fint_c2_pend", 32'(u_if.int_pending_o), 32'd1);
    chk("fint_c2_hold", 32'(u_if.hold_flag_o), 32'd3);
    nxt(); #1;
    chk("fint_c3_jf", 32'(u_if.jump_flag_o), 32'd1);
    chk("fint_c3_ja", u_if.jump_addr_o, 32'h90);
    nxt(); #1;
    chk("fint_c4_pend", 32'(u_if.int_pending_o), 32'd0);
    nxt(); #1;
    nxt(); #1; chk("fint_c6_hold", 32'(u_if.hold_flag_o), 32'd0);

    // Reset in the middle of a flush with an interrupt pending
    nxt(); u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h400; #1;
    nxt(); u_if.int_assert_i = 1'b1; u_if.int_addr_i = 32'hA0; #1;
    nxt(); #1;
    chk("rflush_pend", 32'(u_if.int_pending_o), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk_all_zero("rflush_inrst");
    nxt(); rstn = 1'b1; #1;
    chk("rflush_rel_hold", 32'(u_if.hold_flag_o), 32'd0);
    chk("rflush_rel_pend", 32'(u_if.int_pending_o), 32'd0);
    nxt(); u_if.jump_flag_i = 1'b1; u_if.jump_addr_i = 32'h500; #1;
    chk("rflush_run_jf", 32'(u_if.jump_flag_o), 32'd1);
    chk("rflush_run_ja", u_if.jump_addr_o, 32'h500);
    nxt(); #1;
    nxt(); #1;
    nxt(); #1; chk("rflush_end_hold", 32'(u_if.hold_flag_o), 32'd0);

    // Watchdog: 7 held, gap, 7 held stays quiet
    for (int i = 0; i < 7; i++) begin nxt(); u_if.hold_bus_i = 1'b1; #1; end
    nxt(); #1;
    for (int i = 0; i < 7; i++) begin nxt(); u_if.hold_bus_i = 1'b1; #1; end
    nxt(); #1;
    chk("wd_7gap7", 32'(u_if.stall_timeout_o), 32'd0);

    // Watchdog: 8 consecutive held cycles trip it, and it stays set
    for (int i = 0; i < 8; i++) begin
      nxt(); u_if.hold_bus_i = 1'b1; #1;
      if (i == 7) chk("wd_pre_trip", 32'(u_if.stall_timeout_o), 32'd0);
    end
    nxt(); #1;
    chk("wd_trip", 32'(u_if.stall_timeout_o), 32'(c_WD));
    nxt(); #1;
    nxt(); #1;
    chk("wd_sticky", 32'(u_if.stall_timeout_o), 32'(c_WD));
    chk("wd_hold_none", 32'(u_if.hold_flag_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Pipeline hazard/redirect controller. Produces the `Hold_Flag_Bus` hold code and the PC redirect consumed by the PC register and the if/id and id/ex pipeline registers.
- Those stage registers flush to NOP/zero when the hold code reaches or exceeds their stage level.
- Arbitrates jump, interrupt, multi-cycle EX stalls, load-use hazards and bus wait.
- Sequences the multi-cycle flush and any deferred interrupt redirect.

Parameters:
- FLUSH_CYCLES, 1: total cycles of Hold_Id issued per redirect, including the redirect cycle; legal range 1..15.
- TIMEOUT, 1024: consecutive non-None hold cycles that trip the stall watchdog (optional feature only).

Ports:
- clk  in  1  core clock
- rstn  in  1  reset, active-low, asynchronous
- jump_flag_i  in  1  EX branch/jump taken
- jump_addr_i  in  32  EX target address
- int_assert_i  in  1  interrupt redirect request, single-cycle pulse
- int_addr_i  in  32  interrupt handler address
- hold_ex_i  in  1  EX multi-cycle op (div) busy
- hold_bus_i  in  1  bus not ready
- ex_load_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  EX destination register
- id_rs1_i  in  5  ID source register 1
- id_rs2_i  in  5  ID source register 2
- hold_flag_o  out  3  hold code: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3
- jump_flag_o  out  1  redirect PC this cycle
- jump_addr_o  out  32  redirect target
- int_pending_o  out  1  interrupt latched, awaiting EX release
- stall_timeout_o  out  1  watchdog tripped (0 when feature compiled out)

Behaviour:
- Reset: all state registers clear asynchronously on rstn low.
  - State returns to S_RUN; flush counter 0; pending interrupt and its address 0; watchdog 0.
  - Outputs during reset: hold_flag_o=0, jump_flag_o=0, jump_addr_o=0, int_pending_o=0, stall_timeout_o=0.
  - Reset mid-flush abandons the flush and drops any pending interrupt.
- States: S_RUN, S_FLUSH.
- Redirect source, resolved in S_RUN:
  - A pending interrupt is used if int_pending_o=1 and hold_ex_i=0.
  - Otherwise int_assert_i is used if hold_ex_i=0.
  - Otherwise jump_flag_i is used.
  - The interrupt always beats a jump in the same cycle; the jump is dropped.
- int_assert_i while hold_ex_i=1:
  - Latch int_addr_i and set int_pending_o on the next edge.
  - A second int_assert_i while already pending is ignored; the first address is kept.
- Redirect cycle (combinational, zero latency):
  - jump_flag_o=1; jump_addr_o = selected address; hold_flag_o=Hold_Id.
  - If the source was the pending interrupt, clear int_pending_o on the edge.
  - If FLUSH_CYCLES>1: load counter = FLUSH_CYCLES-1 and go to S_FLUSH. Otherwise stay in S_RUN.
- S_FLUSH:
  - hold_flag_o=Hold_Id and jump_flag_o=0; jump_addr_o holds the last target.
  - Counter decrements each cycle; return to S_RUN when it reaches 1→0.
  - jump_flag_i and hold inputs are ignored, since the EX contents are flushed bubbles.
  - int_assert_i is latched as pending; it is not taken immediately.
- S_RUN with no redirect, priority high to low:
  - hold_ex_i → Hold_Id.
  - Load-use (ex_load_i && ex_rd_i!=0 && (ex_rd_i==id_rs1_i || ex_rd_i==id_rs2_i)) → Hold_Id for that cycle only. The inserted bubble clears ex_load_i the next cycle.
  - hold_bus_i → Hold_Pc.
  - Otherwise → Hold_None.
- When not redirecting, jump_flag_o=0 and jump_addr_o keeps its last registered target.
- Register x0 never creates a load-use hazard.

Optional Feature:
- Macro: PIPE_STALL_WATCHDOG_EN.
- With the macro defined:
  - A 16-bit saturating counter increments on each cycle where hold_flag_o!=Hold_None.
  - It clears on any Hold_None cycle.
  - When the count equals TIMEOUT, stall_timeout_o sets and stays sticky until reset.
  - The hold behaviour itself is unchanged.
- Without the macro: no counter exists and stall_timeout_o is tied to 0.

Test Plan:
- Redirect flush: FLUSH_CYCLES=3, jump_flag_i=1, jump_addr_i=0x100 for 1 cycle.
  - Expect jump_flag_o=1 with 0x100 in cycle 0.
  - Expect hold_flag_o=3 for cycles 0,1,2, then 0 in cycle 3.
- Deferred interrupt: hold_ex_i=1 for 4 cycles; int_assert_i pulse in cycle 1 with int_addr_i=0x80.
  - Expect int_pending_o=1 from cycle 2.
  - In cycle 4 (hold_ex_i=0), expect jump_flag_o=1, jump_addr_o=0x80; int_pending_o=0 in cycle 5.
- Interrupt beats jump: same cycle int_assert_i (addr 0x80) and jump_flag_i (addr 0x200), hold_ex_i=0.
  - Expect jump_addr_o=0x80; the jump is dropped.
- Load-use: ex_load_i=1, ex_rd_i=5, id_rs2_i=5.
  - Expect hold_flag_o=3 for one cycle.
  - Repeat with ex_rd_i=0: expect hold_flag_o=0.
- Bus vs EX priority and reset:
  - hold_bus_i=1 alone: expect hold_flag_o=1.
  - Add hold_ex_i=1: expect 3.
  - Assert rstn=0 mid-S_FLUSH: all outputs 0 immediately; after release, state is S_RUN.
- Watchdog (PIPE_STALL_WATCHDOG_EN, TIMEOUT=8):
  - hold_bus_i=1 for 8 cycles: stall_timeout_o=1 after the 8th cycle and stays 1 after hold_bus_i drops.
  - 7 cycles, a gap, then 7 cycles: stays 0.
